// File: rtl/pattern_alarm_ctrl.sv
// pattern_alarm_ctrl: windowed hit counter that raises a held, acknowledged alarm
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-low reset
//   enable     in   monitoring active
//   hit        in   detector pulse, one per detected pattern
//   ack        in   alarm acknowledge, honoured only after the hold time
//   alarm      out  registered alarm flag
//   hit_count  out  hits in the current window, saturating
//   total_hits out  lifetime hits while enabled, saturating
//   state      out  0 IDLE, 1 ARMED, 2 ALARM
module pattern_alarm_ctrl #(
    parameter int WINDOW = 16,
    parameter int THRESH = 3,
    parameter int HOLD   = 8,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             hit,
    input  logic             ack,
    output logic             alarm,
    output logic [CNT_W-1:0] hit_count,
    output logic [15:0]      total_hits,
    output logic [1:0]       state
);
    localparam int WIN_W  = $clog2(WINDOW);
    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [WIN_W-1:0]  WIN_INIT  = WIN_W'(WINDOW - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, ALARM = 2'd2} state_t;

    state_t            state_q, state_d;
    logic              alarm_q, alarm_d;
    logic [CNT_W-1:0]  hit_count_q, hit_count_d;
    logic [15:0]       total_hits_q, total_hits_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  hc_inc;
    logic              thr_hit;

    assign hc_inc  = (hit_count_q == '1) ? hit_count_q : hit_count_q + CNT_W'(1);
    // One extra bit so the +1 cannot wrap before the threshold compare
    assign thr_hit = ({1'b0, hit_count_q} + (CNT_W+1)'(1)) >= (CNT_W+1)'(THRESH);

    always_comb begin
        state_d      = state_q;
        alarm_d      = alarm_q;
        hit_count_d  = hit_count_q;
        win_cnt_d    = win_cnt_q;
        hold_cnt_d   = (hold_cnt_q == '0) ? hold_cnt_q : hold_cnt_q - HOLD_W'(1);
        total_hits_d = (enable && hit && total_hits_q != 16'hFFFF) ? total_hits_q + 16'd1 : total_hits_q;
        case (state_q)
            IDLE: begin
                hit_count_d = '0;
                if (enable && hit) begin
                    hit_count_d = CNT_W'(1);
                    if (THRESH == 1) begin
                        state_d    = ALARM;
                        alarm_d    = 1'b1;
                        hold_cnt_d = HOLD_INIT;
                    end else begin
                        state_d   = ARMED;
                        win_cnt_d = WIN_INIT;
                    end
                end
            end
            ARMED: begin
                if (!enable) begin
                    state_d     = IDLE;
                    hit_count_d = '0;
                end else if (hit && thr_hit) begin
                    // Threshold hit beats window expiry on the last window cycle
                    state_d     = ALARM;
                    alarm_d     = 1'b1;
                    hit_count_d = hc_inc;
                    hold_cnt_d  = HOLD_INIT;
                end else if (win_cnt_q == '0) begin
                    state_d     = IDLE;
                    hit_count_d = '0;
                end else begin
                    win_cnt_d   = win_cnt_q - WIN_W'(1);
                    hit_count_d = hit ? hc_inc : hit_count_q;
                end
            end
            ALARM: begin
                if (ack && hold_cnt_q == '0) begin
                    state_d     = IDLE;
                    alarm_d     = 1'b0;
                    hit_count_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                alarm_d     = 1'b0;
                hit_count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            alarm_q      <= 1'b0;
            hit_count_q  <= '0;
            total_hits_q <= '0;
            win_cnt_q    <= '0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            alarm_q      <= alarm_d;
            hit_count_q  <= hit_count_d;
            total_hits_q <= total_hits_d;
            win_cnt_q    <= win_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign alarm      = alarm_q;
    assign hit_count  = hit_count_q;
    assign total_hits = total_hits_q;
    assign state      = state_q;
endmodule

// File: tb/tb_pattern_alarm_ctrl.sv
// tb_pattern_alarm_ctrl: directed and random checks against a timestamp-based reference model
module tb_pattern_alarm_ctrl;
    localparam int WINDOW = 16;
    localparam int THRESH = 3;
    localparam int HOLD   = 8;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enable = 1'b0;
    logic             hit = 1'b0;
    logic             ack = 1'b0;
    logic             alarm;
    logic [CNT_W-1:0] hit_count;
    logic [15:0]      total_hits;
    logic [1:0]       state;

    pattern_alarm_ctrl #(.WINDOW(WINDOW), .THRESH(THRESH), .HOLD(HOLD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .hit(hit), .ack(ack),
        .alarm(alarm), .hit_count(hit_count), .total_hits(total_hits), .state(state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: mode 0/1/2, timestamps of hits in the open window, window start edge, alarm entry edge
    int m_mode  = 0;
    int m_hits[$];
    int m_start = 0;
    int m_entry = 0;
    int m_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step(input logic r, input logic en, input logic h, input logic a);
        if (!r) begin
            m_mode = 0;
            m_hits.delete();
            m_total = 0;
        end else begin
            if (en && h && m_total < 65535) m_total++;
            if (m_mode == 0) begin
                if (en && h) begin
                    m_hits.push_back(cyc);
                    if (THRESH == 1) begin
                        m_mode  = 2;
                        m_entry = cyc;
                    end else begin
                        m_mode  = 1;
                        m_start = cyc;
                    end
                end
            end else if (m_mode == 1) begin
                if (!en) begin
                    m_mode = 0;
                    m_hits.delete();
                end else if (h && m_hits.size() + 1 >= THRESH) begin
                    m_hits.push_back(cyc);
                    m_mode  = 2;
                    m_entry = cyc;
                end else if (cyc - m_start >= WINDOW) begin
                    m_mode = 0;
                    m_hits.delete();
                end else if (h) begin
                    m_hits.push_back(cyc);
                end
            end else begin
                if (a && cyc - m_entry >= HOLD) begin
                    m_mode = 0;
                    m_hits.delete();
                end
            end
        end
    endtask

    task automatic tick(input logic r, input logic en, input logic h, input logic a);
        int exp_hc;
        @(negedge clk);
        rst = r;
        enable = en;
        hit = h;
        ack = a;
        @(posedge clk);
        model_step(r, en, h, a);
        cyc++;
        #1;
        exp_hc = (m_hits.size() > 255) ? 255 : m_hits.size();
        check("alarm", 32'(alarm), 32'(m_mode == 2));
        check("state", 32'(state), 32'(m_mode));
        check("hit_count", 32'(hit_count), 32'(exp_hc));
        check("total_hits", 32'(total_hits), 32'(m_total));
    endtask

    initial begin
        // T1 reset with hit and enable high
        tick(0, 1, 1, 0);
        tick(0, 1, 1, 0);
        check("t1_state", 32'(state), 32'd0);
        check("t1_alarm", 32'(alarm), 32'd0);
        check("t1_total", 32'(total_hits), 32'd0);
        // T2 three hits inside the window
        for (int i = 0; i <= 9; i++) tick(1, 1, (i == 0 || i == 4 || i == 9), 0);
        check("t2_state", 32'(state), 32'd2);
        check("t2_alarm", 32'(alarm), 32'd1);
        check("t2_hit_count", 32'(hit_count), 32'd3);
        check("t2_total", 32'(total_hits), 32'd3);
        // T4 early ack ignored, ack after hold honoured
        for (int i = 1; i <= 7; i++) tick(1, 1, 0, 1);
        check("t4_early_ack", 32'(alarm), 32'd1);
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 1);
        check("t4_ack_alarm", 32'(alarm), 32'd0);
        check("t4_ack_state", 32'(state), 32'd0);
        // T3 window expiry with two hits
        tick(0, 0, 0, 0);
        for (int i = 0; i <= 16; i++) begin
            tick(1, 1, (i == 0 || i == 5), 0);
            if (i == 15) check("t3_armed", 32'(state), 32'd1);
        end
        check("t3_state", 32'(state), 32'd0);
        check("t3_hit_count", 32'(hit_count), 32'd0);
        check("t3_alarm", 32'(alarm), 32'd0);
        check("t3_total", 32'(total_hits), 32'd2);
        // T5 disable in ARMED, then disable in ALARM
        tick(0, 0, 0, 0);
        tick(1, 1, 1, 0);
        tick(1, 1, 0, 0);
        tick(1, 0, 1, 0);
        check("t5_armed_off", 32'(state), 32'd0);
        check("t5_armed_hc", 32'(hit_count), 32'd0);
        for (int i = 0; i < 3; i++) tick(1, 1, 1, 0);
        for (int i = 0; i < 10; i++) tick(1, 0, i[0], 0);
        check("t5_alarm_held", 32'(alarm), 32'd1);
        tick(1, 0, 0, 1);
        check("t5_ack", 32'(alarm), 32'd0);
        // T6 threshold hit on the last window cycle
        tick(0, 0, 0, 0);
        for (int i = 0; i <= 16; i++) tick(1, 1, (i == 0 || i == 5 || i == 16), 0);
        check("t6_edge_alarm", 32'(state), 32'd2);
        // Randomized traffic
        tick(0, 0, 0, 0);
        repeat (3000) tick($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
                           $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
        // Lifetime counter saturation
        tick(0, 0, 0, 0);
        repeat (65540) tick(1, 1, 1, 0);
        check("t6_total_sat", 32'(total_hits), 32'hFFFF);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
